// File: rtl/seq_muldiv_alu_pkg.sv
// Shared types for the sequential RV32 ALU: operation codes, engine states and
// helpers that classify operations.
package alu_pkg;

    typedef enum logic [4:0] {
        OpAdd    = 5'd0,
        OpSub    = 5'd1,
        OpSll    = 5'd2,
        OpSrl    = 5'd3,
        OpSra    = 5'd4,
        OpAnd    = 5'd5,
        OpOr     = 5'd6,
        OpXor    = 5'd7,
        OpImm    = 5'd8,
        OpMul    = 5'd9,
        OpMulh   = 5'd10,
        OpMulhsu = 5'd11,
        OpMulhu  = 5'd12,
        OpDiv    = 5'd13,
        OpDivu   = 5'd14,
        OpRem    = 5'd15,
        OpRemu   = 5'd16
    } aluop_t;

    typedef enum logic [1:0] {
        StIdle,
        StMul,
        StDiv
    } alu_state_t;

    function automatic logic is_mul(aluop_t op);
        return op inside {OpMul, OpMulh, OpMulhsu, OpMulhu};
    endfunction

    function automatic logic is_div(aluop_t op);
        return op inside {OpDiv, OpDivu, OpRem, OpRemu};
    endfunction

endpackage

// File: rtl/seq_muldiv_alu_if.sv
// Request/response bundle between the EX-stage control and the sequential ALU.
interface seq_muldiv_alu_if #(
    parameter int unsigned WIDTH = 32
) ();
    import alu_pkg::*;

    logic             start;
    aluop_t           op;
    logic [WIDTH-1:0] opa;
    logic [WIDTH-1:0] opb;
    logic             flush;
    logic             ready;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             Z;
    logic             N;
    logic             V;
    logic             C;

    modport master (
        output start, op, opa, opb, flush,
        input  ready, done, result, Z, N, V, C
    );

    modport slave (
        input  start, op, opa, opb, flush,
        output ready, done, result, Z, N, V, C
    );

endinterface

// File: rtl/seq_muldiv_alu_base_comb.sv
// Single-cycle datapath for the base ALU ops, with overflow and carry flags.
module alu_base_comb
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned SHAMT_W = $clog2(WIDTH)
) (
    input  aluop_t           op_i,
    input  logic [WIDTH-1:0] opa_i,
    input  logic [WIDTH-1:0] opb_i,
    output logic [WIDTH-1:0] result_o,
    output logic             v_o,
    output logic             c_o
);

    logic [SHAMT_W-1:0] shamt;
    logic [WIDTH:0]     sum;
    logic [WIDTH:0]     diff;

    assign shamt = opb_i[SHAMT_W-1:0];
    assign sum   = {1'b0, opa_i} + {1'b0, opb_i};
    // Top bit of diff is the borrow out.
    assign diff  = {1'b0, opa_i} - {1'b0, opb_i};

    always_comb begin
        result_o = '0;
        v_o      = 1'b0;
        c_o      = 1'b0;
        case (op_i)
            OpAdd: begin
                result_o = sum[WIDTH-1:0];
                c_o      = sum[WIDTH];
                v_o      = (opa_i[WIDTH-1] == opb_i[WIDTH-1]) &&
                           (sum[WIDTH-1] != opa_i[WIDTH-1]);
            end
            OpSub: begin
                result_o = diff[WIDTH-1:0];
                c_o      = ~diff[WIDTH];
                v_o      = (opa_i[WIDTH-1] != opb_i[WIDTH-1]) &&
                           (diff[WIDTH-1] != opa_i[WIDTH-1]);
            end
            OpSll:   result_o = opa_i << shamt;
            OpSrl:   result_o = opa_i >> shamt;
            OpSra:   result_o = $signed(opa_i) >>> shamt;
            OpAnd:   result_o = opa_i & opb_i;
            OpOr:    result_o = opa_i | opb_i;
            OpXor:   result_o = opa_i ^ opb_i;
            OpImm:   result_o = opb_i;
            default: result_o = '0;
        endcase
    end

endmodule

// File: rtl/seq_muldiv_alu.sv
// EX-stage ALU: registered base ops plus an iterative shift-add multiplier and
// restoring divider sharing one set of working registers.
module seq_muldiv_alu
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned SHAMT_W = $clog2(WIDTH)
) (
    input logic             clk,
    input logic             rst,
    seq_muldiv_alu_if.slave bus
);

    localparam logic [WIDTH-1:0] MinNeg = {1'b1, {(WIDTH-1){1'b0}}};

    alu_state_t         state_q, state_d;
    aluop_t             op_q, op_d;
    logic [SHAMT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d, mcand_q, mcand_d, result_q, result_d;
    logic               neg_q, neg_d, done_q, done_d;
    logic               z_q, z_d, n_q, n_d, v_q, v_d, c_q, c_d;

    logic [WIDTH-1:0]   base_res, mul_add, rem_next, quo_next, div_val, fin_res;
    logic               base_v, base_c, fin, fin_v, fin_c, sa, sb, signed_div;
    logic [WIDTH:0]     mul_sum, div_trial;
    logic [2*WIDTH-1:0] mul_next, mul_prod;

    alu_base_comb #(
        .WIDTH   (WIDTH),
        .SHAMT_W (SHAMT_W)
    ) u_base (
        .op_i     (bus.op),
        .opa_i    (bus.opa),
        .opb_i    (bus.opb),
        .result_o (base_res),
        .v_o      (base_v),
        .c_o      (base_c)
    );

    // hi holds the partial product / remainder, lo the multiplier / quotient.
    assign mul_add   = lo_q[0] ? mcand_q : '0;
    assign mul_sum   = {1'b0, hi_q} + {1'b0, mul_add};
    assign mul_next  = {mul_sum, lo_q[WIDTH-1:1]};
    assign mul_prod  = neg_q ? -mul_next : mul_next;
    assign div_trial = {hi_q, lo_q[WIDTH-1]} - {1'b0, mcand_q};
    assign rem_next  = div_trial[WIDTH] ? {hi_q[WIDTH-2:0], lo_q[WIDTH-1]}
                                        : div_trial[WIDTH-1:0];
    assign quo_next  = {lo_q[WIDTH-2:0], ~div_trial[WIDTH]};
    assign div_val   = (op_q inside {OpDiv, OpDivu}) ? quo_next : rem_next;

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        cnt_d      = cnt_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        mcand_d    = mcand_q;
        neg_d      = neg_q;
        result_d   = result_q;
        z_d        = z_q;
        n_d        = n_q;
        v_d        = v_q;
        c_d        = c_q;
        done_d     = 1'b0;
        fin        = 1'b0;
        fin_res    = '0;
        fin_v      = 1'b0;
        fin_c      = 1'b0;
        sa         = 1'b0;
        sb         = 1'b0;
        signed_div = bus.op inside {OpDiv, OpRem};

        if (bus.flush) begin
            state_d = StIdle;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (bus.start && is_mul(bus.op)) begin
                        sa      = (bus.op inside {OpMulh, OpMulhsu}) && bus.opa[WIDTH-1];
                        sb      = (bus.op == OpMulh) && bus.opb[WIDTH-1];
                        mcand_d = sa ? -bus.opa : bus.opa;
                        lo_d    = sb ? -bus.opb : bus.opb;
                        hi_d    = '0;
                        neg_d   = sa ^ sb;
                        op_d    = bus.op;
                        cnt_d   = SHAMT_W'(WIDTH - 1);
                        state_d = StMul;
                    end else if (bus.start && is_div(bus.op)) begin
                        sa = signed_div && bus.opa[WIDTH-1];
                        sb = signed_div && bus.opb[WIDTH-1];
                        if (bus.opb == '0) begin
                            fin     = 1'b1;
                            fin_res = (bus.op inside {OpDiv, OpDivu}) ? '1 : bus.opa;
                        end else if (signed_div && bus.opa == MinNeg && bus.opb == '1) begin
                            fin     = 1'b1;
                            fin_v   = 1'b1;
                            fin_res = (bus.op == OpDiv) ? bus.opa : '0;
                        end else begin
                            lo_d    = sa ? -bus.opa : bus.opa;
                            mcand_d = sb ? -bus.opb : bus.opb;
                            hi_d    = '0;
                            // Remainder takes the dividend's sign, quotient the xor.
                            neg_d   = (bus.op == OpRem) ? sa : (sa ^ sb);
                            op_d    = bus.op;
                            cnt_d   = SHAMT_W'(WIDTH - 1);
                            state_d = StDiv;
                        end
                    end else if (bus.start) begin
                        fin     = 1'b1;
                        fin_res = base_res;
                        fin_v   = base_v;
                        fin_c   = base_c;
                    end
                end
                StMul: begin
                    hi_d  = mul_next[2*WIDTH-1:WIDTH];
                    lo_d  = mul_next[WIDTH-1:0];
                    cnt_d = cnt_q - SHAMT_W'(1);
                    if (cnt_q == '0) begin
                        fin     = 1'b1;
                        fin_res = (op_q == OpMul) ? mul_prod[WIDTH-1:0]
                                                  : mul_prod[2*WIDTH-1:WIDTH];
                        state_d = StIdle;
                    end
                end
                StDiv: begin
                    hi_d  = rem_next;
                    lo_d  = quo_next;
                    cnt_d = cnt_q - SHAMT_W'(1);
                    if (cnt_q == '0) begin
                        fin     = 1'b1;
                        fin_res = neg_q ? -div_val : div_val;
                        state_d = StIdle;
                    end
                end
                default: state_d = StIdle;
            endcase
        end

        if (fin) begin
            result_d = fin_res;
            z_d      = (fin_res == '0);
            n_d      = fin_res[WIDTH-1];
            v_d      = fin_v;
            c_d      = fin_c;
            done_d   = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            op_q     <= OpAdd;
            cnt_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            mcand_q  <= '0;
            neg_q    <= 1'b0;
            result_q <= '0;
            done_q   <= 1'b0;
            z_q      <= 1'b1;
            n_q      <= 1'b0;
            v_q      <= 1'b0;
            c_q      <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            cnt_q    <= cnt_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            mcand_q  <= mcand_d;
            neg_q    <= neg_d;
            result_q <= result_d;
            done_q   <= done_d;
            z_q      <= z_d;
            n_q      <= n_d;
            v_q      <= v_d;
            c_q      <= c_d;
        end
    end

    assign bus.ready  = (state_q == StIdle);
    assign bus.done   = done_q;
    assign bus.result = result_q;
    assign bus.Z      = z_q;
    assign bus.N      = n_q;
    assign bus.V      = v_q;
    assign bus.C      = c_q;

endmodule
